// File: rtl/sram_bus_ctrl_if.sv
// sram_bus_ctrl_if: MEM-stage request/response and SRAM pin bundle for sram_bus_ctrl
interface sram_bus_ctrl_if #(
    parameter int ADDR_W = 19
) ();
    logic              req;
    logic              we;
    logic [3:0]        sel;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stallreq;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_o;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    modport slave (
        input  req, we, sel, addr, wdata, sram_dq_i,
        output rdata, stallreq, done, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output req, we, sel, addr, wdata, sram_dq_i,
        input  rdata, stallreq, done, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: splits 32-bit MEM-stage accesses into wait-stated 16-bit async SRAM beats
module sram_bus_ctrl #(
    parameter int ADDR_W      = 19,
    parameter int CPU_DW      = 32,
    parameter int SRAM_DW     = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            rst,
    sram_bus_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

    localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait
        $fatal(1, "sram_bus_ctrl: WAIT_CYCLES must be in 2..15");
    end
    if (CPU_DW != 32 || SRAM_DW != 16) begin : g_bad_width
        $fatal(1, "sram_bus_ctrl: only CPU_DW=32 / SRAM_DW=16 supported");
    end

    state_t            state, state_nx;
    logic [3:0]        wcnt;
    logic [ADDR_W-2:0] a_addr;
    logic              a_we;
    logic [3:0]        a_sel;
    logic [31:0]       a_wdata;
    logic              beat, hi, last;
    logic              unused_addr_bits;

    // next state and SRAM pin decode from the latched access
    always_comb begin
        beat             = state == BEAT0 || state == BEAT1;
        hi               = state == BEAT1;
        last             = wcnt == WLAST;
        state_nx         = state;
        unused_addr_bits = ^{bus.addr[31:ADDR_W+1], bus.addr[1:0]};
        case (state)
            IDLE:    if (bus.req) state_nx = |bus.sel[1:0] ? BEAT0 : |bus.sel[3:2] ? BEAT1 : DONE;
            BEAT0:   if (last) state_nx = |a_sel[3:2] ? BEAT1 : DONE;
            BEAT1:   if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        bus.sram_addr  = beat ? {a_addr, hi} : '0;
        bus.sram_ce_n  = ~beat;
        bus.sram_oe_n  = ~(beat & ~a_we);
        bus.sram_we_n  = ~(beat & a_we & ~last);
        bus.sram_dq_oe = beat & a_we;
        bus.sram_dq_o  = (beat & a_we) ? (hi ? a_wdata[31:16] : a_wdata[15:0]) : '0;
        bus.sram_ub_n  = ~(beat & (hi ? a_sel[3] : a_sel[1]));
        bus.sram_lb_n  = ~(beat & (hi ? a_sel[2] : a_sel[0]));
        bus.done       = state == DONE;
        bus.stallreq   = bus.req & (state != DONE) & ~rst;
    end

    // state register and per-beat wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (beat && !last) ? wcnt + 4'd1 : '0;
        end
    end

    // access latch in IDLE and load data capture on the last wait cycle of each beat
    always_ff @(posedge clk) begin
        if (rst) begin
            a_addr    <= '0;
            a_we      <= 1'b0;
            a_sel     <= '0;
            a_wdata   <= '0;
            bus.rdata <= '0;
        end else begin
            if (state == IDLE && bus.req) begin
                a_addr  <= bus.addr[ADDR_W:2];
                a_we    <= bus.we;
                a_sel   <= bus.sel;
                a_wdata <= bus.wdata;
                if (!bus.we) bus.rdata <= '0;
            end
            if (beat && last && !a_we) begin
                if (hi) bus.rdata[31:16] <= bus.sram_dq_i;
                else    bus.rdata[15:0]  <= bus.sram_dq_i;
            end
        end
    end
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: vector table, corner sequences and random traffic against a byte-level model
module tb_sram_bus_ctrl;
    localparam int W  = 2;
    localparam int AW = 19;

    typedef struct {
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          dc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] smem [int];
    logic [7:0] rmem [int];
    vec_t       tbl [10];

    sram_bus_ctrl_if #(.ADDR_W(AW)) bus ();

    sram_bus_ctrl #(.ADDR_W(AW), .CPU_DW(32), .SRAM_DW(16), .WAIT_CYCLES(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] sbyte(int k);
        return smem.exists(k) ? smem[k] : 8'h00;
    endfunction

    function automatic logic [7:0] rbyte(int k);
        return rmem.exists(k) ? rmem[k] : 8'h00;
    endfunction

    // async SRAM pin model: byte-lane writes while we_n is low, reads while oe_n is low
    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            if (!bus.sram_lb_n) smem[2*int'(bus.sram_addr)]     = bus.sram_dq_o[7:0];
            if (!bus.sram_ub_n) smem[2*int'(bus.sram_addr) + 1] = bus.sram_dq_o[15:8];
        end
    end

    always @(negedge clk)
        bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ?
            {sbyte(2*int'(bus.sram_addr) + 1), sbyte(2*int'(bus.sram_addr))} : 16'hA5A5;

    function automatic int base_of(logic [31:0] a);
        return int'({a[AW:2], 2'b00});
    endfunction

    function automatic int beats(logic [3:0] s);
        return int'(|s[1:0]) + int'(|s[3:2]);
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] a, logic [3:0] s);
        logic [31:0] r = '0;
        int b = base_of(a);
        for (int h = 0; h < 2; h++)
            if (s[2*h +: 2] != 2'b00) r[16*h +: 16] = {rbyte(b + 2*h + 1), rbyte(b + 2*h)};
        return r;
    endfunction

    function automatic void model_store(logic [31:0] a, logic [3:0] s, logic [31:0] d);
        int b = base_of(a);
        for (int i = 0; i < 4; i++) if (s[i]) rmem[b + i] = d[8*i +: 8];
    endfunction

    task automatic poke(input int hw, input logic [15:0] v);
        smem[2*hw]     = v[7:0];
        smem[2*hw + 1] = v[15:8];
        rmem[2*hw]     = v[7:0];
        rmem[2*hw + 1] = v[15:8];
    endtask

    // one access starting at posedge+1 of an IDLE cycle; ends at posedge+1 after the done cycle
    task automatic access(input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic drop,
                          output int dcyc, output logic [31:0] rd);
        int bl [2];
        int nb, cyc, stc, cec, wec, n;
        logic [1:0]  ln;
        logic [15:0] hd;
        logic        wl;
        bl = '{0, 0};
        nb = 0;
        if (s[1:0] != 2'b00) begin bl[nb] = 0; nb++; end
        if (s[3:2] != 2'b00) begin bl[nb] = 1; nb++; end
        bus.req = 1'b1; bus.we = w; bus.sel = s; bus.addr = a; bus.wdata = d;
        dcyc = -1; cyc = 0; stc = 0; cec = 0; wec = 0; rd = '0;
        while (dcyc < 0 && cyc < 64) begin
            @(negedge clk);
            if (bus.stallreq) stc++;
            if (!bus.sram_ce_n) cec++;
            if (!bus.sram_we_n) wec++;
            if (cyc >= 1 && cyc <= nb*W) begin
                n  = bl[(cyc-1)/W];
                ln = n[0] ? ~s[3:2] : ~s[1:0];
                hd = n[0] ? d[31:16] : d[15:0];
                wl = !w || ((cyc-1) % W == W-1);
                chk("sram_addr", 64'(bus.sram_addr), 64'({a[AW:2], n[0]}));
                chk("ub_lb_n", {bus.sram_ub_n, bus.sram_lb_n}, ln);
                chk("oe_n", bus.sram_oe_n, w);
                chk("we_n", bus.sram_we_n, wl);
                chk("dq_oe", bus.sram_dq_oe, w);
                if (w) chk("dq_o", bus.sram_dq_o, hd);
            end
            if (bus.done) begin
                dcyc = cyc;
                rd   = bus.rdata;
            end
            @(posedge clk); #1;
            cyc++;
            if (drop) bus.req = 1'b0;
        end
        bus.req = 1'b0;
        chk("stall_cycles", stc, drop ? 1 : nb*W + 1);
        chk("ce_cycles", cec, nb*W);
        chk("we_low_cycles", wec, w ? nb*(W-1) : 0);
    endtask

    initial begin
        int          dc, nd;
        logic [31:0] rd, ex, a, d;
        logic [3:0]  s;
        logic        w, drop;

        tbl[0] = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         5};
        tbl[1] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 5};
        tbl[2] = '{1'b1, 4'h4, 32'h0000_0012, 32'h00AB_0000, 32'h0,         3};
        tbl[3] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAB_BEEF, 5};
        tbl[4] = '{1'b0, 4'h3, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 3};
        tbl[5] = '{1'b0, 4'h8, 32'h0000_0010, 32'h0,         32'hDEAB_0000, 3};
        tbl[6] = '{1'b1, 4'h0, 32'h0000_0010, 32'h1111_1111, 32'h0,         1};
        tbl[7] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h0,         1};
        tbl[8] = '{1'b1, 4'h2, 32'h0000_0014, 32'h0000_CD00, 32'h0,         3};
        tbl[9] = '{1'b0, 4'hF, 32'hABC0_0014, 32'h0,         32'h0000_CD00, 5};

        bus.req = 1'b1; bus.we = 1'b0; bus.sel = 4'hF; bus.addr = 32'h10; bus.wdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_stallreq", bus.stallreq, 1'b0);
            chk("rst_rdata", bus.rdata, 32'h0);
            chk("rst_ctrl_n", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}, 5'h1F);
            chk("rst_dq_oe", bus.sram_dq_oe, 1'b0);
            chk("rst_done", bus.done, 1'b0);
            chk("rst_sram_addr", 64'(bus.sram_addr), 64'h0);
            chk("rst_dq_o", bus.sram_dq_o, 16'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.req = 1'b0;
        @(posedge clk); #1;

        poke(8, 16'h1234);
        poke(9, 16'h5678);
        access(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, dc, rd);
        chk("t3_done_cycle", dc, 5);
        chk("t3_rdata", rd, 32'h5678_1234);
        chk("t3_rdata_held", bus.rdata, 32'h5678_1234);
        @(negedge clk);
        chk("t3_rdata_held2", bus.rdata, 32'h5678_1234);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            access(tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, 1'b0, dc, rd);
            chk($sformatf("vec%0d_done_cycle", i), dc, tbl[i].dc);
            if (tbl[i].w) model_store(tbl[i].a, tbl[i].s, tbl[i].d);
            else begin
                chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
                chk($sformatf("vec%0d_rdata_held", i), bus.rdata, tbl[i].rd);
            end
        end

        ex = exp_load(32'h10, 4'hF);
        access(1'b0, 4'hF, 32'h10, 32'h0, 1'b1, dc, rd);
        chk("drop_done_cycle", dc, 5);
        chk("drop_rdata", rd, ex);

        for (int k = 0; k < 200; k++) begin
            w    = 1'($urandom_range(0, 1));
            s    = 4'($urandom_range(0, 15));
            a    = ($urandom() & 32'hFFF0_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            d    = $urandom();
            drop = $urandom_range(0, 7) == 0;
            ex   = exp_load(a, s);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            access(w, s, a, d, drop, dc, rd);
            chk("rnd_done_cycle", dc, 1 + beats(s)*W);
            if (w) model_store(a, s, d);
            else chk("rnd_rdata", rd, ex);
        end

        bus.req = 1'b1; bus.we = 1'b1; bus.sel = 4'hF; bus.addr = 32'h400; bus.wdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stallreq", bus.stallreq, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; bus.req = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n, bus.sram_dq_oe}, 6'b111110);
        chk("rst_mid_done", bus.done, 1'b0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("rst_mid_no_done", nd, 0);
        @(posedge clk); #1;
        ex = exp_load(32'h10, 4'hF);
        access(1'b0, 4'hF, 32'h10, 32'h0, 1'b0, dc, rd);
        chk("post_rst_done_cycle", dc, 5);
        chk("post_rst_rdata", rd, ex);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
